// File: rtl/pipelined_adder_n_if.sv
// Streaming add/subtract bus: operand side (in_*, a, b, c_in, sub) and
// result side (out_*, sum, c_out, ovf), each with a valid/ready handshake.
//   master : producer of operands and consumer of results
//   slave  : the adder itself
interface pipelined_adder_n_if #(
    parameter int WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/pipelined_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor, STAGES slices of WIDTH/STAGES bits,
// one slice per clock with the carry registered between slices.
//   {c_out, sum} = a + (sub ? ~b : b) + c_in ; ovf = signed overflow
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of pipelined_adder_n_if (operand and result handshakes)
// The whole pipe advances only when the result slot is free or being
// consumed (en); in_ready is that same enable.
module pipelined_adder_n #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst_n,
    pipelined_adder_n_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    logic en;
    logic ovf_q;

    // Stage k sees the operands with slices 0..k-1 already stripped off, so
    // its slice is always in the low SW bits; skew registers narrow by SW per
    // stage. Finished result slices are appended below the new slice, so the
    // last stage holds all WIDTH result bits aligned.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * SW;
        localparam int RW = (k + 1) * SW;

        logic [IW-1:0] a_in;
        logic [IW-1:0] b_in;
        logic          c_i;
        logic          v_i;
        logic [SW:0]   slice;
        logic [RW-1:0] r_nx;
        logic [RW-1:0] r_q;
        logic          c_q;
        logic          v_q;

        if (k == 0) begin : g_head
            assign a_in = bus.a;
            assign b_in = bus.sub ? ~bus.b : bus.b;
            assign c_i  = bus.c_in;
            assign v_i  = bus.in_valid && en;
            assign r_nx = slice[SW-1:0];
        end else begin : g_body
            assign a_in = g_stage[k-1].g_skew.a_q;
            assign b_in = g_stage[k-1].g_skew.b_q;
            assign c_i  = g_stage[k-1].c_q;
            assign v_i  = g_stage[k-1].v_q;
            assign r_nx = {slice[SW-1:0], g_stage[k-1].r_q};
        end

        assign slice = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_i};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                r_q <= r_nx;
                c_q <= slice[SW];
                v_q <= v_i;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [IW-SW-1:0] a_q;
            logic [IW-SW-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[IW-1:SW];
                    b_q <= b_in[IW-1:SW];
                end
            end
        end else begin : g_tail
            // Top slice holds the operand sign bits (b already inverted).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= (a_in[SW-1] == b_in[SW-1]) && (slice[SW-1] != a_in[SW-1]);
                end
            end
        end
    end

    assign en            = !g_stage[STAGES-1].v_q || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].r_q;
    assign bus.c_out     = g_stage[STAGES-1].c_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder_n.sv
// Bench for pipelined_adder_n: four instances (64/4, 64/1, 32/8, 16/16)
// driven with shared stimulus, each checked against an arithmetic model.
module tb_pipelined_adder_n;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic        sub;
    logic        out_ready;

    int wid [N];
    int lat [N];
    int checks = 0;
    int errors = 0;

    logic        ov [N];
    logic        ir [N];
    logic        co [N];
    logic        of [N];
    logic [63:0] sm [N];

    always #5 clk = ~clk;

    pipelined_adder_n_if #(.WIDTH(64)) if0 ();
    pipelined_adder_n_if #(.WIDTH(64)) if1 ();
    pipelined_adder_n_if #(.WIDTH(32)) if2 ();
    pipelined_adder_n_if #(.WIDTH(16)) if3 ();

    assign if0.in_valid = in_valid;  assign if0.a = a;        assign if0.b = b;
    assign if0.c_in = c_in;          assign if0.sub = sub;    assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.a = a;        assign if1.b = b;
    assign if1.c_in = c_in;          assign if1.sub = sub;    assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.a = a[31:0];  assign if2.b = b[31:0];
    assign if2.c_in = c_in;          assign if2.sub = sub;    assign if2.out_ready = out_ready;
    assign if3.in_valid = in_valid;  assign if3.a = a[15:0];  assign if3.b = b[15:0];
    assign if3.c_in = c_in;          assign if3.sub = sub;    assign if3.out_ready = out_ready;

    pipelined_adder_n #(.WIDTH(64), .STAGES(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    pipelined_adder_n #(.WIDTH(64), .STAGES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pipelined_adder_n #(.WIDTH(32), .STAGES(8))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    pipelined_adder_n #(.WIDTH(16), .STAGES(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign ov[0] = if0.out_valid;  assign ir[0] = if0.in_ready;  assign co[0] = if0.c_out;
    assign of[0] = if0.ovf;        assign sm[0] = if0.sum;
    assign ov[1] = if1.out_valid;  assign ir[1] = if1.in_ready;  assign co[1] = if1.c_out;
    assign of[1] = if1.ovf;        assign sm[1] = if1.sum;
    assign ov[2] = if2.out_valid;  assign ir[2] = if2.in_ready;  assign co[2] = if2.c_out;
    assign of[2] = if2.ovf;        assign sm[2] = {32'b0, if2.sum};
    assign ov[3] = if3.out_valid;  assign ir[3] = if3.in_ready;  assign co[3] = if3.c_out;
    assign of[3] = if3.ovf;        assign sm[3] = {48'b0, if3.sum};

    // Reference: integer add in w bits; overflow = signed result out of range.
    function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic ci,
                                          input logic sb);
        logic [63:0]        mask;
        logic [63:0]        am;
        logic [63:0]        bm;
        logic [65:0]        u;
        logic signed [66:0] sa;
        logic signed [66:0] sbs;
        logic signed [66:0] s;
        logic signed [66:0] lim;
        logic [65:0]        r;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = av & mask;
        bm   = (sb ? ~bv : bv) & mask;
        u    = {2'b0, am} + {2'b0, bm} + {65'b0, ci};
        sa   = $signed({3'b000, am});
        if (am[w-1]) sa = sa - (67'sd1 <<< w);
        sbs  = $signed({3'b000, bm});
        if (bm[w-1]) sbs = sbs - (67'sd1 <<< w);
        s    = sa + sbs + $signed({66'b0, ci});
        lim  = 67'sd1 <<< (w - 1);
        r[63:0] = u[63:0] & mask;
        r[64]   = u[w];
        r[65]   = (s >= lim) || (s < -lim);
        return r;
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || sm[i] !== 64'd0 || co[i] !== 1'b0 || of[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got v=%b sum=%h c=%b o=%b expected all zero",
                         i, ov[i], sm[i], co[i], of[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ir[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready inst%0d: got %b expected 1", i, ir[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry_ripple();
        bit seen [N];
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        out_ready = 1'b1;
        a = '1; b = 64'd1; c_in = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    checks++;
                    if (n != lat[i]) begin
                        errors++;
                        $display("FAIL ripple_latency inst%0d: got %0d expected %0d", i, n, lat[i]);
                    end
                    checks++;
                    if (sm[i] !== 64'd0 || co[i] !== 1'b1 || of[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL ripple_value inst%0d: got sum=%h c=%b o=%b expected sum=0 c=1 o=0",
                                 i, sm[i], co[i], of[i]);
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!seen[i]) begin
                checks++;
                errors++;
                $display("FAIL ripple_timeout inst%0d: got no out_valid expected one after %0d cycles", i, lat[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ta [16];
        logic [63:0] tbv [16];
        logic        tc [16];
        logic        ts [16];
        int          got [N];
        int          run [N];
        int          maxrun [N];
        logic [65:0] exp_v;
        for (int j = 0; j < 16; j++) begin
            ta[j]  = {$urandom, $urandom};
            tbv[j] = {$urandom, $urandom};
            tc[j]  = 1'($urandom_range(0, 1));
            ts[j]  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < N; i++) begin
            got[i] = 0; run[i] = 0; maxrun[i] = 0;
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < 16) begin
                in_valid = 1'b1;
                a = ta[cyc]; b = tbv[cyc]; c_in = tc[cyc]; sub = ts[cyc];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ov[i]) begin
                    run[i]++;
                    if (run[i] > maxrun[i]) maxrun[i] = run[i];
                    checks++;
                    if (got[i] >= 16) begin
                        errors++;
                        $display("FAIL b2b_extra inst%0d: got result #%0d expected at most 16", i, got[i] + 1);
                    end else begin
                        exp_v = model(wid[i], ta[got[i]], tbv[got[i]], tc[got[i]], ts[got[i]]);
                        if ({of[i], co[i], sm[i]} !== exp_v) begin
                            errors++;
                            $display("FAIL b2b_data inst%0d #%0d: got o=%b c=%b sum=%h expected o=%b c=%b sum=%h",
                                     i, got[i], of[i], co[i], sm[i], exp_v[65], exp_v[64], exp_v[63:0]);
                        end
                    end
                    got[i]++;
                end else begin
                    run[i] = 0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] != 16 || maxrun[i] != 16) begin
                errors++;
                $display("FAIL b2b_stream inst%0d: got count=%0d run=%0d expected count=16 run=16",
                         i, got[i], maxrun[i]);
            end
        end
    endtask

    task automatic test_subtract();
        logic [63:0] sa [2];
        logic [63:0] sbv [2];
        logic [65:0] exp0 [2];
        logic [65:0] exp_v;
        int          got [N];
        sa[0] = 64'd5;                  sbv[0] = 64'd7;
        sa[1] = 64'h8000_0000_0000_0000; sbv[1] = 64'd1;
        exp0[0] = {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        exp0[1] = {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
        for (int i = 0; i < N; i++) got[i] = 0;
        out_ready = 1'b1;
        c_in = 1'b1; sub = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc < 2) begin
                in_valid = 1'b1; a = sa[cyc]; b = sbv[cyc];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ov[i]) begin
                    checks++;
                    if (got[i] >= 2) begin
                        errors++;
                        $display("FAIL sub_extra inst%0d: got result #%0d expected at most 2", i, got[i] + 1);
                    end else begin
                        exp_v = (i == 0) ? exp0[got[i]] : model(wid[i], sa[got[i]], sbv[got[i]], 1'b1, 1'b1);
                        if ({of[i], co[i], sm[i]} !== exp_v) begin
                            errors++;
                            $display("FAIL sub_data inst%0d #%0d: got o=%b c=%b sum=%h expected o=%b c=%b sum=%h",
                                     i, got[i], of[i], co[i], sm[i], exp_v[65], exp_v[64], exp_v[63:0]);
                        end
                    end
                    got[i]++;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] != 2) begin
                errors++;
                $display("FAIL sub_count inst%0d: got %0d expected 2", i, got[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] pa [8];
        logic [63:0] pb [8];
        logic        pc [8];
        logic        ps [8];
        int          n_acc = 0;
        int          n_del = 0;
        int          left = 0;
        int          extra = 0;
        bit          started = 1'b0;
        bit          acc;
        bit          xfer;
        logic [63:0] held = '0;
        logic [65:0] exp_v;
        for (int j = 0; j < 8; j++) begin
            pa[j] = {$urandom, $urandom};
            pb[j] = {$urandom, $urandom};
            pc[j] = 1'($urandom_range(0, 1));
            ps[j] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 60 && n_del < 8; cyc++) begin
            if (!started && ov[0]) begin
                started = 1'b1;
                left    = 5;
                held    = sm[0];
            end
            out_ready = (left == 0);
            in_valid  = (n_acc < 8);
            if (n_acc < 8) begin
                a = pa[n_acc]; b = pb[n_acc]; c_in = pc[n_acc]; sub = ps[n_acc];
            end
            #1;
            acc  = in_valid && ir[0];
            xfer = ov[0] && out_ready;
            if (!out_ready) begin
                checks++;
                if (ir[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got %b expected 0", ir[0]);
                end
                checks++;
                if (sm[0] !== held || ov[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b sum=%h expected v=1 sum=%h", ov[0], sm[0], held);
                end
            end
            if (xfer) begin
                checks++;
                if (n_del >= 8) begin
                    errors++;
                    $display("FAIL bp_extra: got result #%0d expected at most 8", n_del + 1);
                end else begin
                    exp_v = model(64, pa[n_del], pb[n_del], pc[n_del], ps[n_del]);
                    if ({of[0], co[0], sm[0]} !== exp_v) begin
                        errors++;
                        $display("FAIL bp_data #%0d: got o=%b c=%b sum=%h expected o=%b c=%b sum=%h",
                                 n_del, of[0], co[0], sm[0], exp_v[65], exp_v[64], exp_v[63:0]);
                    end
                end
                n_del++;
            end
            if (acc) n_acc++;
            @(posedge clk);
            #1;
            if (left > 0) left--;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (n_del != 8 || !started) begin
            errors++;
            $display("FAIL bp_count: got delivered=%0d stalled=%0d expected delivered=8 stalled=1", n_del, started);
        end
        repeat (8) begin
            if (ov[0]) extra++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL bp_duplicate: got %0d extra results expected 0", extra);
        end
        idle(20);
    endtask

    task automatic test_reset_midstream();
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic        rs;
        logic [65:0] exp_v;
        int          stale [N];
        bit          seen [N];
        out_ready = 1'b1;
        repeat (3) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || sm[i] !== 64'd0 || co[i] !== 1'b0 || of[i] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_clear inst%0d: got v=%b sum=%h c=%b o=%b expected all zero",
                         i, ov[i], sm[i], co[i], of[i]);
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ir[i] !== 1'b1) begin
                errors++;
                $display("FAIL midreset_in_ready inst%0d: got %b expected 1", i, ir[i]);
            end
            stale[i] = 0;
            seen[i]  = 1'b0;
        end
        repeat (20) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (ov[i]) stale[i]++;
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (stale[i] != 0) begin
                errors++;
                $display("FAIL midreset_stale inst%0d: got %0d valid cycles expected 0", i, stale[i]);
            end
        end
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        a = ra; b = rb; c_in = rc; sub = rs;
        in_valid = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    checks++;
                    if (n != lat[i]) begin
                        errors++;
                        $display("FAIL midreset_latency inst%0d: got %0d expected %0d", i, n, lat[i]);
                    end
                    checks++;
                    exp_v = model(wid[i], ra, rb, rc, rs);
                    if ({of[i], co[i], sm[i]} !== exp_v) begin
                        errors++;
                        $display("FAIL midreset_data inst%0d: got o=%b c=%b sum=%h expected o=%b c=%b sum=%h",
                                 i, of[i], co[i], sm[i], exp_v[65], exp_v[64], exp_v[63:0]);
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!seen[i]) begin
                checks++;
                errors++;
                $display("FAIL midreset_timeout inst%0d: got no out_valid expected one after %0d cycles", i, lat[i]);
            end
        end
    endtask

    initial begin
        wid[0] = 64; lat[0] = 4;
        wid[1] = 64; lat[1] = 1;
        wid[2] = 32; lat[2] = 8;
        wid[3] = 16; lat[3] = 16;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_carry_ripple();
        idle(4);
        test_back_to_back();
        idle(4);
        test_subtract();
        idle(4);
        test_backpressure();
        test_reset_midstream();
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000 time units");
        $fatal(1, "bench timed out");
    end
endmodule
